// File: rtl/rll_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rll_pkg
//  Description : Shared types for the RLL(2,7) frame controller: controller
//                FSM states, source-phrase tracker states and the default
//                preamble length.
//  Revision    : 1.0 - initial release
// ============================================================================
package rll_pkg;

    // Default number of "11" preamble pairs ahead of the payload.
    localparam int unsigned c_pre_pairs_default = 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        PAYLOAD  = 3'd2,
        FLUSH    = 3'd3,
        DONE     = 3'd4
    } ctrl_state_t;

    // Prefix of the RLL(2,7) source phrase gathered so far.
    typedef enum logic [2:0] {
        EMPTY = 3'd0,
        P1    = 3'd1,
        P0    = 3'd2,
        P00   = 3'd3,
        P01   = 3'd4,
        P001  = 3'd5
    } phrase_state_t;

endpackage
`default_nettype wire

// File: rtl/rll_phrase_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : rll_phrase_tracker
//  Description : Follows the serial bit stream and reports when the current
//                bit completes an RLL(2,7) source phrase
//                (10, 11, 000, 010, 011, 0010, 0011).
//  Ports       : clk_i, ari      - clock, async active-low reset
//                bit_i, en_i    - stream bit and its qualifier
//                clr_i          - return to EMPTY (start of frame)
//                state_o        - current phrase prefix
//                phrase_done_o  - bit_i completes a phrase this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module rll_phrase_tracker
    import rll_pkg::*;
(
    input  logic          clk_i,
    input  logic          ari,
    input  logic          bit_i,
    input  logic          en_i,
    input  logic          clr_i,
    output phrase_state_t state_o,
    output logic          phrase_done_o
);

    phrase_state_t state_q;
    phrase_state_t state_d;
    logic          w_done;

    always_comb begin
        state_d = state_q;
        w_done  = 1'b0;
        if (clr_i) begin
            state_d = EMPTY;
        end else if (en_i) begin
            case (state_q)
                EMPTY:   state_d = bit_i ? P1 : P0;
                P0:      state_d = bit_i ? P01 : P00;
                P00: begin
                    if (bit_i) begin
                        state_d = P001;
                    end else begin
                        state_d = EMPTY;
                        w_done  = 1'b1;
                    end
                end
                // P1, P01 and P001 complete on either bit value.
                default: begin
                    state_d = EMPTY;
                    w_done  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge ari) begin
        if (!ari) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o       = state_q;
    assign phrase_done_o = w_done;

endmodule
`default_nettype wire

// File: rtl/rll_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : rll_frame_ctrl
//  Description : Serialises a byte-stream frame for an RLL(2,7) encoder:
//                preamble of "11" pairs, payload MSB first, then zero bits
//                until the last source phrase is complete.
//  Ports       : clk_i, ari                 - clock, async active-low reset
//                byte_i/byte_valid_i/sof_i/eof_i, byte_ready_o - byte input
//                enc_data_o/enc_en_o        - serial bit to the encoder
//                phrase_done_o              - bit completes a source phrase
//                busy_o, frame_done_o       - frame status
//                underrun_o                 - sticky payload underrun
//                bits_sent_o                - bits emitted in the frame
//  Revision    : 1.0 - initial release
// ============================================================================
module rll_frame_ctrl
    import rll_pkg::*;
#(
    parameter int unsigned PRE_PAIRS = c_pre_pairs_default
) (
    input  logic        clk_i,
    input  logic        ari,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    input  logic        sof_i,
    input  logic        eof_i,
    output logic        byte_ready_o,
    output logic        enc_data_o,
    output logic        enc_en_o,
    output logic        phrase_done_o,
    output logic        busy_o,
    output logic        frame_done_o,
    output logic        underrun_o,
    output logic [15:0] bits_sent_o
);

    localparam logic [8:0] c_pre_last = 9'(2 * PRE_PAIRS - 1);

    ctrl_state_t   state_q, state_d;
    logic [8:0]    pre_cnt_q, pre_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          eof_q, eof_d;
    logic          underrun_q, underrun_d;
    logic [15:0]   bits_sent_q, bits_sent_d;

    logic          w_enc_en;
    logic          w_enc_bit;
    logic          w_clr;
    logic          w_phrase_done;
    phrase_state_t w_ph_state;

    rll_phrase_tracker u_tracker (
        .clk_i         (clk_i),
        .ari           (ari),
        .bit_i         (w_enc_bit),
        .en_i          (w_enc_en),
        .clr_i         (w_clr),
        .state_o       (w_ph_state),
        .phrase_done_o (w_phrase_done)
    );

    // Serial output depends only on registered state, so the tracker's
    // phrase_done can feed the next-state logic without a loop.
    always_comb begin
        w_enc_en  = 1'b0;
        w_enc_bit = 1'b0;
        case (state_q)
            PREAMBLE: begin
                w_enc_en  = 1'b1;
                w_enc_bit = 1'b1;
            end
            PAYLOAD: begin
                w_enc_en  = 1'b1;
                w_enc_bit = shift_q[7];
            end
            FLUSH:    w_enc_en = (w_ph_state != EMPTY);
            default:  ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        pre_cnt_d    = pre_cnt_q;
        shift_d      = shift_q;
        bit_idx_d    = bit_idx_q;
        eof_d        = eof_q;
        underrun_d   = underrun_q;
        bits_sent_d  = bits_sent_q;
        byte_ready_o = 1'b0;
        frame_done_o = 1'b0;
        w_clr        = 1'b0;

        if (w_enc_en && (bits_sent_q != 16'hFFFF)) begin
            bits_sent_d = bits_sent_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                // Ready is held low for as long as reset is applied.
                byte_ready_o = ari;
                if (byte_valid_i && sof_i) begin
                    shift_d     = byte_i;
                    eof_d       = eof_i;
                    bits_sent_d = 16'd0;
                    underrun_d  = 1'b0;
                    pre_cnt_d   = 9'd0;
                    bit_idx_d   = 3'd0;
                    w_clr       = 1'b1;
                    state_d     = PREAMBLE;
                end
            end
            PREAMBLE: begin
                // The SOF byte still sits unsent in the shift register, so
                // the first payload request is made at its bit 7.
                if (pre_cnt_q == c_pre_last) begin
                    bit_idx_d = 3'd0;
                    state_d   = PAYLOAD;
                end else begin
                    pre_cnt_d = pre_cnt_q + 9'd1;
                end
            end
            PAYLOAD: begin
                shift_d   = {shift_q[6:0], 1'b0};
                bit_idx_d = bit_idx_q + 3'd1;
                if (bit_idx_q == 3'd7) begin
                    if (eof_q) begin
                        state_d = w_phrase_done ? DONE : FLUSH;
                    end else begin
                        byte_ready_o = 1'b1;
                        if (byte_valid_i) begin
                            // sof_i is meaningless mid-frame.
                            shift_d = byte_i;
                            eof_d   = eof_i;
                        end else begin
                            underrun_d = 1'b1;
                            state_d    = w_phrase_done ? DONE : FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (w_phrase_done || (w_ph_state == EMPTY)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                frame_done_o = 1'b1;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge ari) begin
        if (!ari) begin
            state_q     <= IDLE;
            pre_cnt_q   <= 9'd0;
            shift_q     <= 8'd0;
            bit_idx_q   <= 3'd0;
            eof_q       <= 1'b0;
            underrun_q  <= 1'b0;
            bits_sent_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            pre_cnt_q   <= pre_cnt_d;
            shift_q     <= shift_d;
            bit_idx_q   <= bit_idx_d;
            eof_q       <= eof_d;
            underrun_q  <= underrun_d;
            bits_sent_q <= bits_sent_d;
        end
    end

    assign enc_en_o      = w_enc_en;
    assign enc_data_o    = w_enc_bit;
    assign phrase_done_o = w_phrase_done;
    assign busy_o        = (state_q != IDLE);
    assign underrun_o    = underrun_q;
    assign bits_sent_o   = bits_sent_q;

endmodule
`default_nettype wire

// File: tb/tb_rll_frame_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_rll_frame_ctrl
//  Description : Self-checking bench for rll_frame_ctrl (PRE_PAIRS = 2).
//                A phrase model predicts every encoder bit and phrase_done
//                flag; a table of frames supplies stimulus and frame-level
//                results; reset and back-to-back cases are hand sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rll_frame_ctrl;

    localparam int unsigned PRE_PAIRS = 2;

    logic        clk_i = 1'b0;
    logic        ari;
    logic [7:0]  byte_i;
    logic        byte_valid_i;
    logic        sof_i;
    logic        eof_i;
    logic        byte_ready_o;
    logic        enc_data_o;
    logic        enc_en_o;
    logic        phrase_done_o;
    logic        busy_o;
    logic        frame_done_o;
    logic        underrun_o;
    logic [15:0] bits_sent_o;

    rll_frame_ctrl #(.PRE_PAIRS(PRE_PAIRS)) dut (
        .clk_i         (clk_i),
        .ari           (ari),
        .byte_i        (byte_i),
        .byte_valid_i  (byte_valid_i),
        .sof_i         (sof_i),
        .eof_i         (eof_i),
        .byte_ready_o  (byte_ready_o),
        .enc_data_o    (enc_data_o),
        .enc_en_o      (enc_en_o),
        .phrase_done_o (phrase_done_o),
        .busy_o        (busy_o),
        .frame_done_o  (frame_done_o),
        .underrun_o    (underrun_o),
        .bits_sent_o   (bits_sent_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard entries: {data bit, phrase_done}.
    logic [1:0] exp_q[$];
    logic [3:0] acc;
    int         acc_len;

    typedef struct {
        logic [7:0] b [3];
        int         nb;
        bit         mid_sof;
        bit         eof_last;
        int         exp_bits;
        bit         exp_underrun;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Phrase model: collect bits and close the phrase when the collected
    // pattern is one of 10, 11, 000, 010, 011, 0010, 0011.
    task automatic model_push(input logic b);
        logic done;
        acc = {acc[2:0], b};
        acc_len++;
        done = (acc_len == 2 && acc[1]) ||
               (acc_len == 3 && (acc[2:0] == 3'b000 || acc[2:0] == 3'b010 || acc[2:0] == 3'b011)) ||
               (acc_len == 4 && acc[3:1] == 3'b001);
        exp_q.push_back({b, done});
        if (done) begin
            acc_len = 0;
            acc     = 4'd0;
        end
    endtask

    task automatic model_frame(input vec_t v);
        acc_len = 0;
        acc     = 4'd0;
        for (int i = 0; i < 2 * PRE_PAIRS; i++) model_push(1'b1);
        for (int k = 0; k < v.nb; k++)
            for (int j = 7; j >= 0; j--) model_push(v.b[k][j]);
        while (acc_len != 0) model_push(1'b0);
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (byte_ready_o !== 1'b1 && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
        check({name, "_ready_seen"}, 32'(byte_ready_o), 32'd1);
    endtask

    task automatic drive_frame(input vec_t v);
        for (int k = 0; k < v.nb; k++) begin
            byte_i       = v.b[k];
            byte_valid_i = 1'b1;
            sof_i        = (k == 0) || (v.mid_sof && k == 1);
            eof_i        = v.eof_last && (k == v.nb - 1);
            wait_ready("drive");
            @(posedge clk_i); #1;
            byte_valid_i = 1'b0;
            sof_i        = 1'b0;
            eof_i        = 1'b0;
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (frame_done_o !== 1'b1 && n < 400) begin
            @(negedge clk_i);
            n++;
        end
        check({name, "_done_seen"}, 32'(frame_done_o), 32'd1);
    endtask

    task automatic finish_frame(input string name, input int exp_bits, input bit exp_ur);
        wait_done(name);
        check({name, "_bits_sent"}, 32'(bits_sent_o), 32'(exp_bits));
        check({name, "_underrun"}, 32'(underrun_o), 32'(exp_ur));
        check({name, "_busy_in_done"}, 32'(busy_o), 32'd1);
        check({name, "_ready_in_done"}, 32'(byte_ready_o), 32'd0);
        check({name, "_en_in_done"}, 32'(enc_en_o), 32'd0);
        check({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk_i);
        check({name, "_idle_after"}, 32'(busy_o), 32'd0);
        check({name, "_bits_hold"}, 32'(bits_sent_o), 32'(exp_bits));
    endtask

    // Bit monitor: every encoder bit is compared with the model.
    always @(negedge clk_i) begin
        logic [1:0] e;
        if (ari === 1'b1) begin
            if (enc_en_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_bit: enc_en_o=1 data=%b with no bit expected (t=%0t)", enc_data_o, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("enc_data", 32'(enc_data_o), 32'(e[1]));
                    check("phrase_done", 32'(phrase_done_o), 32'(e[0]));
                end
            end else begin
                check("data_zero_when_idle", 32'(enc_data_o), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        ari          = 1'b0;
        byte_i       = 8'h00;
        byte_valid_i = 1'b0;
        sof_i        = 1'b0;
        eof_i        = 1'b0;
        acc          = 4'd0;
        acc_len      = 0;

        //               bytes              nb mid eof bits ur
        vecs[0] = '{'{8'hB4, 8'h00, 8'h00}, 1, 0, 1, 14, 0};
        vecs[1] = '{'{8'h01, 8'h00, 8'h00}, 1, 0, 1, 13, 0};
        vecs[2] = '{'{8'hA5, 8'h3C, 8'hFF}, 3, 1, 1, 28, 0};
        vecs[3] = '{'{8'hC3, 8'h00, 8'h00}, 1, 0, 0, 12, 1};
        vecs[4] = '{'{8'hB4, 8'h00, 8'h00}, 1, 0, 0, 14, 1};

        // Reset state
        #1;
        check("rst_ready", 32'(byte_ready_o), 32'd0);
        check("rst_en", 32'(enc_en_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_bits_sent", 32'(bits_sent_o), 32'd0);
        check("rst_underrun", 32'(underrun_o), 32'd0);
        repeat (3) @(posedge clk_i);
        #1 ari = 1'b1;
        @(posedge clk_i); #1;
        check("idle_ready", 32'(byte_ready_o), 32'd1);

        // Table of frames
        for (int i = 0; i < 5; i++) begin
            model_frame(vecs[i]);
            drive_frame(vecs[i]);
            finish_frame($sformatf("vec%0d", i), vecs[i].exp_bits, vecs[i].exp_underrun);
        end

        // Back-to-back: SOF offered in the DONE cycle waits for IDLE
        model_frame(vecs[1]);
        drive_frame(vecs[1]);
        wait_done("b2b_first");
        check("b2b_first_bits", 32'(bits_sent_o), 32'd13);
        check("b2b_ready_in_done", 32'(byte_ready_o), 32'd0);
        model_frame(vecs[0]);
        byte_i = 8'hB4; byte_valid_i = 1'b1; sof_i = 1'b1; eof_i = 1'b1;
        @(posedge clk_i); #1;
        check("b2b_not_taken_in_done", 32'(busy_o), 32'd0);
        check("b2b_ready_in_idle", 32'(byte_ready_o), 32'd1);
        @(posedge clk_i); #1;
        byte_valid_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;
        check("b2b_busy", 32'(busy_o), 32'd1);
        check("b2b_preamble_en", 32'(enc_en_o), 32'd1);
        check("b2b_bits_cleared", 32'(bits_sent_o), 32'd0);
        finish_frame("b2b_second", 14, 1'b0);

        // Reset during payload bit 3
        acc_len = 0;
        acc     = 4'd0;
        for (int i = 0; i < 2 * PRE_PAIRS; i++) model_push(1'b1);
        model_push(1'b1); model_push(1'b0); model_push(1'b1);
        byte_i = 8'hB4; byte_valid_i = 1'b1; sof_i = 1'b1; eof_i = 1'b1;
        wait_ready("rst_mid");
        @(posedge clk_i); #1;
        byte_valid_i = 1'b0; sof_i = 1'b0; eof_i = 1'b0;
        repeat (7) @(posedge clk_i);
        #2;
        check("pre_rst_bit3_en", 32'(enc_en_o), 32'd1);
        check("pre_rst_bit3_data", 32'(enc_data_o), 32'd1);
        ari = 1'b0;
        #1;
        check("mid_rst_en", 32'(enc_en_o), 32'd0);
        check("mid_rst_data", 32'(enc_data_o), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_ready", 32'(byte_ready_o), 32'd0);
        check("mid_rst_bits", 32'(bits_sent_o), 32'd0);
        check("mid_rst_pd", 32'(phrase_done_o), 32'd0);
        check("mid_rst_queue", 32'(exp_q.size()), 32'd0);
        repeat (2) @(posedge clk_i);
        #3 ari = 1'b1;
        byte_i = 8'h55; byte_valid_i = 1'b1; sof_i = 1'b0; eof_i = 1'b1;
        @(posedge clk_i); #1;
        check("nosof_ready", 32'(byte_ready_o), 32'd1);
        check("nosof_discard_busy", 32'(busy_o), 32'd0);
        @(posedge clk_i); #1;
        byte_valid_i = 1'b0; eof_i = 1'b0;
        check("nosof_still_idle", 32'(busy_o), 32'd0);
        check("nosof_bits_zero", 32'(bits_sent_o), 32'd0);

        // Clean frame after reset: tracker must start from EMPTY
        v = vecs[1];
        model_frame(v);
        drive_frame(v);
        finish_frame("post_rst", 13, 1'b0);

        repeat (2) @(posedge clk_i);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
